seq_window_gen: RTL and testbench

Generates a qualified two-phase handshake: on a `start` request it raises a window strobe `win` and, inside that window, a one-cycle `x` pulse followed by a one-cycle `y` pulse, with programmable lead, gap and tail cycles. It is the stimulus and design stage directly upstream of the `start |=> win throughout (x ##1 y)`-style property checkers. It feeds `start`, `win` (exp), `x` and `y` to those checkers. Requests arriving while busy are queued in a saturating pending counter.

---
 rtl/seq_window_pkg.sv | 16 +
 rtl/win_cnt.sv | 31 +++
 rtl/seq_window_gen.sv | 153 +++++++++++++++
 tb/tb_seq_window_gen.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_window_pkg.sv
// Shared types and default sizing for the window/handshake generator.
package seq_window_pkg;

    localparam int CW_DEF       = 4;
    localparam int PEND_MAX_DEF = 3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        XPH  = 3'd2,
        GAP  = 3'd3,
        YPH  = 3'd4,
        POST = 3'd5
    } state_t;

endpackage

// File: rtl/win_cnt.sv
// Loadable down-counter shared by the PRE, GAP and POST phases.
// `last` flags the final cycle of a phase (count == 1).
module win_cnt
    import seq_window_pkg::*;
#(
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          dec,
    input  logic [CW-1:0] load_val,
    output logic          last
);

    logic [CW-1:0] count;

    // Load takes priority; decrement never wraps below zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - CW'(1);
        end
    end

    assign last = (count == CW'(1));

endmodule

// File: rtl/seq_window_gen.sv
// Two-phase handshake stimulus generator: win window enclosing an x pulse
// then a y pulse, with programmable lead/gap/tail and a saturating request queue.
//
//   state | meaning
//   ------+-----------------------------------------------
//   IDLE  | no window; launches on start or queued request
//   PRE   | win only, counting the lead cycles
//   XPH   | win and x pulse
//   GAP   | win only, counting the cycles between x and y
//   YPH   | win and y pulse
//   POST  | win only, counting the tail cycles
module seq_window_gen
    import seq_window_pkg::*;
#(
    parameter int CW       = CW_DEF,
    parameter int PEND_MAX = PEND_MAX_DEF,
    localparam int PW      = $clog2(PEND_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [CW-1:0] pre_cyc,
    input  logic [CW-1:0] gap_cyc,
    input  logic [CW-1:0] post_cyc,
    output logic          win,
    output logic          x,
    output logic          y,
    output logic          busy,
    output logic          done,
    output logic          drop,
    output logic [PW-1:0] pend
);

    state_t        state, state_nxt;
    logic [CW-1:0] gap_q, post_q;
    logic          launch;
    logic          cnt_load, cnt_dec, cnt_last;
    logic [CW-1:0] cnt_val;
    logic [PW-1:0] pend_nxt;
    logic          drop_nxt;
    logic          done_nxt;

    win_cnt #(.CW(CW)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (cnt_val),
        .last     (cnt_last)
    );

    // Next-state, counter control and queue bookkeeping.
    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        cnt_val   = '0;
        unique case (state)
            IDLE: begin
                if (start || (pend != '0)) begin
                    launch    = 1'b1;
                    cnt_load  = 1'b1;
                    cnt_val   = pre_cyc;
                    state_nxt = (pre_cyc != '0) ? PRE : XPH;
                end
            end
            PRE: begin
                if (cnt_last) state_nxt = XPH;
                else          cnt_dec   = 1'b1;
            end
            XPH: begin
                if (gap_q != '0) begin
                    state_nxt = GAP;
                    cnt_load  = 1'b1;
                    cnt_val   = gap_q;
                end else begin
                    state_nxt = YPH;
                end
            end
            GAP: begin
                if (cnt_last) state_nxt = YPH;
                else          cnt_dec   = 1'b1;
            end
            YPH: begin
                if (post_q != '0) begin
                    state_nxt = POST;
                    cnt_load  = 1'b1;
                    cnt_val   = post_q;
                end else begin
                    state_nxt = IDLE;
                end
            end
            POST: begin
                if (cnt_last) state_nxt = IDLE;
                else          cnt_dec   = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase

        // A start during a window is queued; a start at a launch edge with a
        // non-empty queue is serviced while the oldest queued entry waits on.
        pend_nxt = pend;
        drop_nxt = 1'b0;
        if (state != IDLE) begin
            if (start) begin
                if (pend == PW'(PEND_MAX)) drop_nxt = 1'b1;
                else                       pend_nxt = pend + PW'(1);
            end
        end else if (launch && !start && (pend != '0)) begin
            pend_nxt = pend - PW'(1);
        end

        done_nxt = (state != IDLE) && (state_nxt == IDLE);
    end

    // State register and the latched gap/tail of the running transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            gap_q  <= '0;
            post_q <= '0;
        end else begin
            state <= state_nxt;
            if (launch) begin
                gap_q  <= gap_cyc;
                post_q <= post_cyc;
            end
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win  <= 1'b0;
            x    <= 1'b0;
            y    <= 1'b0;
            done <= 1'b0;
            drop <= 1'b0;
            pend <= '0;
        end else begin
            win  <= (state_nxt != IDLE);
            x    <= (state_nxt == XPH);
            y    <= (state_nxt == YPH);
            done <= done_nxt;
            drop <= drop_nxt;
            pend <= pend_nxt;
        end
    end

    assign busy = win;

endmodule

// File: tb/tb_seq_window_gen.sv
// Directed bench for seq_window_gen: per-edge vector table plus hand-written
// sequences for the max-lead and asynchronous-reset corners.
module tb_seq_window_gen;

    localparam int CW       = 4;
    localparam int PEND_MAX = 3;
    localparam int PW       = $clog2(PEND_MAX + 1);
    localparam int OW       = 6 + PW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] pre_cyc = '0, gap_cyc = '0, post_cyc = '0;
    logic          win, x, y, busy, done, drop;
    logic [PW-1:0] pend;

    int n_tests = 0;
    int n_fail  = 0;

    seq_window_gen #(.CW(CW), .PEND_MAX(PEND_MAX)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .pre_cyc  (pre_cyc),
        .gap_cyc  (gap_cyc),
        .post_cyc (post_cyc),
        .win      (win),
        .x        (x),
        .y        (y),
        .busy     (busy),
        .done     (done),
        .drop     (drop),
        .pend     (pend)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          start;
        logic [CW-1:0] pre, gap, post;
        logic          win, x, y, done, drop;
        logic [PW-1:0] pend;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic s, input int p, input int g, input int t,
                       input logic w, input logic xx, input logic yy,
                       input logic d, input logic dr, input int pn);
        vec_t v;
        v.start = s;
        v.pre   = CW'(p);
        v.gap   = CW'(g);
        v.post  = CW'(t);
        v.win   = w;
        v.x     = xx;
        v.y     = yy;
        v.done  = d;
        v.drop  = dr;
        v.pend  = PW'(pn);
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {win,x,y,busy,done,drop,pend}=%b expected %b", name, act, exp);
        end
    endtask

    function automatic logic [OW-1:0] outs();
        return {win, x, y, busy, done, drop, pend};
    endfunction

    initial begin
        int n;
        int low;
        logic found;

        // Rows are edges 1.. after reset release: inputs driven for that edge,
        // outputs expected as sampled at that edge.
        // A: P=G=T=0
        add(1,0,0,0, 0,0,0,0,0,0);
        add(0,0,0,0, 1,1,0,0,0,0);
        add(0,0,0,0, 1,0,1,0,0,0);
        add(0,0,0,0, 0,0,0,1,0,0);
        add(0,0,0,0, 0,0,0,0,0,0);
        // B: P=1 G=0 T=1
        add(1,1,0,1, 0,0,0,0,0,0);
        add(0,1,0,1, 1,0,0,0,0,0);
        add(0,1,0,1, 1,1,0,0,0,0);
        add(0,1,0,1, 1,0,1,0,0,0);
        add(0,1,0,1, 1,0,0,0,0,0);
        add(0,1,0,1, 0,0,0,1,0,0);
        add(0,1,0,1, 0,0,0,0,0,0);
        // C: G=1
        add(1,0,1,0, 0,0,0,0,0,0);
        add(0,0,1,0, 1,1,0,0,0,0);
        add(0,0,1,0, 1,0,0,0,0,0);
        add(0,0,1,0, 1,0,1,0,0,0);
        add(0,0,1,0, 0,0,0,1,0,0);
        add(0,0,1,0, 0,0,0,0,0,0);
        // D: start held for 8 edges, queue saturation and drain
        add(1,0,0,0, 0,0,0,0,0,0);
        add(1,0,0,0, 1,1,0,0,0,0);
        add(1,0,0,0, 1,0,1,0,0,1);
        add(1,0,0,0, 0,0,0,1,0,2);
        add(1,0,0,0, 1,1,0,0,0,2);
        add(1,0,0,0, 1,0,1,0,0,3);
        add(1,0,0,0, 0,0,0,1,1,3);
        add(1,0,0,0, 1,1,0,0,0,3);
        add(0,0,0,0, 1,0,1,0,1,3);
        add(0,0,0,0, 0,0,0,1,0,3);
        add(0,0,0,0, 1,1,0,0,0,2);
        add(0,0,0,0, 1,0,1,0,0,2);
        add(0,0,0,0, 0,0,0,1,0,2);
        add(0,0,0,0, 1,1,0,0,0,1);
        add(0,0,0,0, 1,0,1,0,0,1);
        add(0,0,0,0, 0,0,0,1,0,1);
        add(0,0,0,0, 1,1,0,0,0,0);
        add(0,0,0,0, 1,0,1,0,0,0);
        add(0,0,0,0, 0,0,0,1,0,0);
        add(0,0,0,0, 0,0,0,0,0,0);
        // F: launch with start and pend=1; config changes after launch ignored
        add(1,0,0,0, 0,0,0,0,0,0);
        add(1,0,0,0, 1,1,0,0,0,0);
        add(0,0,0,0, 1,0,1,0,0,1);
        add(1,1,1,1, 0,0,0,1,0,1);
        add(0,3,3,3, 1,0,0,0,0,1);
        add(0,3,3,3, 1,1,0,0,0,1);
        add(0,3,3,3, 1,0,0,0,0,1);
        add(0,3,3,3, 1,0,1,0,0,1);
        add(0,3,3,3, 1,0,0,0,0,1);
        add(0,0,0,0, 0,0,0,1,0,1);
        add(0,0,0,0, 1,1,0,0,0,0);
        add(0,0,0,0, 1,0,1,0,0,0);
        add(0,0,0,0, 0,0,0,1,0,0);
        add(0,0,0,0, 0,0,0,0,0,0);

        repeat (3) @(negedge clk);
        check("reset_state", outs(), '0);
        rst_n = 1'b1;

        foreach (vq[i]) begin
            check($sformatf("vec_edge%0d", i + 1), outs(),
                  {vq[i].win, vq[i].x, vq[i].y, vq[i].win, vq[i].done, vq[i].drop, vq[i].pend});
            start    = vq[i].start;
            pre_cyc  = vq[i].pre;
            gap_cyc  = vq[i].gap;
            post_cyc = vq[i].post;
            @(negedge clk);
        end

        // Maximum lead: x must appear 16 edges after the launch edge.
        start = 1'b1; pre_cyc = 4'd15; gap_cyc = '0; post_cyc = '0;
        @(negedge clk);
        start = 1'b0;
        n = 1; low = 0; found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (x) begin
                found = 1'b1;
                break;
            end
            if (!win) low++;
            n++;
            @(negedge clk);
        end
        n_tests++;
        if (!found || n != 16) begin
            n_fail++;
            $display("FAIL maxpre_x_edge: got x at edge offset %0d (found=%0b) expected 16", n, found);
        end
        n_tests++;
        if (low != 0) begin
            n_fail++;
            $display("FAIL maxpre_win_low: got %0d low-win cycles before x expected 0", low);
        end
        @(negedge clk);
        check("maxpre_y", outs(), {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, PW'(0)});
        @(negedge clk);
        check("maxpre_done", outs(), {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, PW'(0)});

        // Asynchronous reset while in GAP with two requests queued.
        start = 1'b1; pre_cyc = '0; gap_cyc = 4'd3; post_cyc = '0;
        @(negedge clk);
        check("gap_seq_x", outs(), {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, PW'(0)});
        @(negedge clk);
        check("gap_seq_gap1", outs(), {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, PW'(1)});
        @(negedge clk);
        start = 1'b0;
        check("gap_seq_gap2", outs(), {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, PW'(2)});
        #2 rst_n = 1'b0;
        #1 check("async_reset", outs(), '0);
        @(negedge clk);
        @(negedge clk);
        check("held_reset", outs(), '0);
        rst_n = 1'b1;
        start = 1'b1; gap_cyc = '0;
        @(negedge clk);
        start = 1'b0;
        check("post_reset_x", outs(), {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, PW'(0)});
        @(negedge clk);
        check("post_reset_y", outs(), {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, PW'(0)});
        @(negedge clk);
        check("post_reset_done", outs(), {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, PW'(0)});
        @(negedge clk);
        check("post_reset_idle", outs(), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
